regfile_access_ctrl: RTL

Request/response front-end for the `register_file` block. It accepts one read/write request per handshake from a pipeline initiator and drives the register file's write and two read ports. It returns both read operands on a valid/ready response channel. It also enforces hardwired-zero x0 and out-of-range address policy, so initiators never touch the raw register file ports directly.

---
 rtl/regfile_access_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/regfile_access_ctrl.sv
// Request/response front-end for register_file: issues one write and two reads per request.
// Define REGFILE_CTRL_STATS_EN to add saturating write/response counters.
module regfile_access_ctrl #(
  parameter int unsigned REG_NUMBER = 32,
  parameter int unsigned REG_DATA_W = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  rf_clk,
  input  logic                  rf_ares,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [REG_ADDR_W-1:0] req_waddr,
  input  logic [REG_DATA_W-1:0] req_wdata,
  input  logic [REG_ADDR_W-1:0] req_raddr1,
  input  logic [REG_ADDR_W-1:0] req_raddr2,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [REG_DATA_W-1:0] rsp_rdata1,
  output logic [REG_DATA_W-1:0] rsp_rdata2,
  output logic                  rsp_err,
  output logic                  rf_wen,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [REG_DATA_W-1:0] rf_wdata,
  output logic [REG_ADDR_W-1:0] rf_raddr1,
  output logic [REG_ADDR_W-1:0] rf_raddr2,
`ifdef REGFILE_CTRL_STATS_EN
  output logic [15:0]           stat_wr_cnt,
  output logic [15:0]           stat_rd_cnt,
`endif
  input  logic [REG_DATA_W-1:0] rf_rdata1,
  input  logic [REG_DATA_W-1:0] rf_rdata2
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e                r_state, w_state_nxt;
  logic                  r_rf_wen;
  logic [REG_ADDR_W-1:0] r_rf_waddr, r_rf_raddr1, r_rf_raddr2;
  logic [REG_DATA_W-1:0] r_rf_wdata, r_rsp_rdata1, r_rsp_rdata2;
  logic                  r_rsp_err;
  logic                  w_accept, w_rsp_hs, w_wr_ok, w_err;
  logic [REG_DATA_W-1:0] w_rd1, w_rd2;

  function automatic logic f_in_range(input logic [REG_ADDR_W-1:0] a);
    return 32'(a) < REG_NUMBER;
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    unique case (r_state)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) w_state_nxt = StIssue;
      end
      StIssue: w_state_nxt = StWait;
      StWait:  w_state_nxt = StResp;
      StResp: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  assign w_accept = req_valid & req_ready;
  assign w_rsp_hs = rsp_valid & rsp_ready;
  // x0 is hardwired zero: such writes are dropped without raising an error
  assign w_wr_ok  = req_we & (req_waddr != '0) & f_in_range(req_waddr);
  assign w_err    = (req_we & ~f_in_range(req_waddr)) | ~f_in_range(req_raddr1)
                  | ~f_in_range(req_raddr2);
  assign w_rd1    = ((r_rf_raddr1 != '0) && f_in_range(r_rf_raddr1)) ? rf_rdata1 : '0;
  assign w_rd2    = ((r_rf_raddr2 != '0) && f_in_range(r_rf_raddr2)) ? rf_rdata2 : '0;

  always_ff @(posedge rf_clk) begin
    if (rf_ares) begin
      r_state      <= StIdle;
      r_rf_wen     <= 1'b0;
      r_rf_waddr   <= '0;
      r_rf_wdata   <= '0;
      r_rf_raddr1  <= '0;
      r_rf_raddr2  <= '0;
      r_rsp_rdata1 <= '0;
      r_rsp_rdata2 <= '0;
      r_rsp_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_rf_wen <= 1'b0;
      // Request fields go straight into the rf port registers, so ISSUE drives them
      if (w_accept) begin
        r_rf_wen    <= w_wr_ok;
        r_rf_waddr  <= req_waddr;
        r_rf_wdata  <= req_wdata;
        r_rf_raddr1 <= req_raddr1;
        r_rf_raddr2 <= req_raddr2;
        r_rsp_err   <= w_err;
      end
      if (r_state == StWait) begin
        r_rsp_rdata1 <= w_rd1;
        r_rsp_rdata2 <= w_rd2;
      end
    end
  end

  assign rf_wen     = r_rf_wen;
  assign rf_waddr   = r_rf_waddr;
  assign rf_wdata   = r_rf_wdata;
  assign rf_raddr1  = r_rf_raddr1;
  assign rf_raddr2  = r_rf_raddr2;
  assign rsp_rdata1 = r_rsp_rdata1;
  assign rsp_rdata2 = r_rsp_rdata2;
  assign rsp_err    = r_rsp_err;

`ifdef REGFILE_CTRL_STATS_EN
  logic [15:0] r_stat_wr, r_stat_rd;

  always_ff @(posedge rf_clk) begin
    if (rf_ares) begin
      r_stat_wr <= '0;
      r_stat_rd <= '0;
    end else begin
      if (r_rf_wen && (r_stat_wr != 16'hFFFF)) r_stat_wr <= r_stat_wr + 16'd1;
      if (w_rsp_hs && (r_stat_rd != 16'hFFFF)) r_stat_rd <= r_stat_rd + 16'd1;
    end
  end

  assign stat_wr_cnt = r_stat_wr;
  assign stat_rd_cnt = r_stat_rd;
`endif

endmodule
